// File: rtl/tmon_sched_pkg.sv
// Shared definitions for the tmon request scheduler: opcodes, booleans,
// data width and scheduler state encoding.
package tmon_sched_pkg;

    localparam int TMON_DATA_W = 8;

    typedef enum logic [2:0] {
        NOOP      = 3'd0,
        READ_TEMP = 3'd1,
        SET_HI    = 3'd2,
        SET_LO    = 3'd3,
        READ_STAT = 3'd4
    } tmon_op_t;

    typedef enum logic {
        FALSE = 1'b0,
        TRUE  = 1'b1
    } bool_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        GAP  = 2'd2
    } sched_state_e;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_WAIT = WAIT;
    localparam logic [1:0] ST_GAP  = GAP;

endpackage

// File: rtl/tmon_rr_arb.sv
// Combinational round-robin picker: the first valid index strictly after
// ptr_i, wrapping modulo N_REQ.
module tmon_rr_arb
    import tmon_sched_pkg::*;
#(
    parameter  int N_REQ = 3,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] winner_o,
    output bool_t            any_valid_o
);

    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        winner_o = '0;
        found    = 1'b0;
        idx      = ptr_i;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
            if (!found && valid_i[idx]) begin
                found    = 1'b1;
                winner_o = idx;
            end
        end
        any_valid_o = bool_t'(|valid_i);
    end

endmodule

// File: rtl/tmon_sched.sv
// Round-robin scheduler sharing the tmon_master request port among N_REQ
// requesters. Optional autopoll (READ_TEMP every POLL_CLOCKS) via TMON_AUTOPOLL_EN.
module tmon_sched
    import tmon_sched_pkg::*;
#(
    parameter  int N_REQ          = 3,
    parameter  int TIMEOUT_CLOCKS = 64,
    parameter  int POLL_CLOCKS    = 16,
    localparam int GID_W          = $clog2(N_REQ)
) (
    input  logic                                Clock,
    input  logic                                Reset,
    input  logic     [N_REQ-1:0]                req_valid,
    input  tmon_op_t [N_REQ-1:0]                req_op,
    input  logic     [N_REQ-1:0][TMON_DATA_W-1:0] req_data,
    output logic     [N_REQ-1:0]                req_ack,
    output logic                                req_err,
    output logic     [GID_W-1:0]                grant_id,
    output logic                                busy,
    output tmon_op_t                            request,
    output logic     [TMON_DATA_W-1:0]          reqData,
    input  logic                                Done,
    output logic     [1:0]                      dbg_state_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CLOCKS);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CLOCKS < 2 || POLL_CLOCKS < 1) begin : g_param_check
        $error("tmon_sched: parameter out of range");
    end

    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [GID_W-1:0]       rr_q, rr_d;
    logic [GID_W-1:0]       gid_q, gid_d;
    tmon_op_t               request_q, request_d;
    logic [TMON_DATA_W-1:0] data_q, data_d;
    logic [N_REQ-1:0]       ack_q, ack_d;
    logic                   err_q, err_d;

    logic [N_REQ-1:0]       valid_m;
    logic [GID_W-1:0]       win;
    bool_t                  any_valid;
    logic                   poll_pending;
    logic                   poll_active;

    // A requester just acked in IDLE (NOOP op) is not re-granted before it can drop valid.
    assign valid_m = req_valid & ~ack_q;

    tmon_rr_arb #(.N_REQ(N_REQ)) u_arb (
        .valid_i     (valid_m),
        .ptr_i       (rr_q),
        .winner_o    (win),
        .any_valid_o (any_valid)
    );

`ifdef TMON_AUTOPOLL_EN
    localparam int PW = $clog2(POLL_CLOCKS + 1);

    logic [PW-1:0] poll_cnt_q;
    logic          poll_pend_q;
    logic          poll_act_q;
    logic          poll_tick;

    assign poll_tick = (poll_cnt_q == PW'(POLL_CLOCKS - 1));

    // Pending poll is always taken in IDLE, so it only survives outside IDLE.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            poll_cnt_q  <= '0;
            poll_pend_q <= 1'b0;
            poll_act_q  <= 1'b0;
        end else begin
            poll_cnt_q  <= poll_tick ? '0 : poll_cnt_q + 1'b1;
            poll_pend_q <= poll_tick | (poll_pend_q & (state_q != ST_IDLE));
            if (state_q == ST_IDLE) begin
                poll_act_q <= poll_pend_q;
            end
        end
    end

    assign poll_pending = poll_pend_q;
    assign poll_active  = poll_act_q;
`else
    assign poll_pending = 1'b0;
    assign poll_active  = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        gid_d     = gid_q;
        request_d = request_q;
        data_d    = data_q;
        ack_d     = '0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (poll_pending) begin
                    request_d = READ_TEMP;
                    data_d    = '0;
                    cnt_d     = '0;
                    state_d   = ST_WAIT;
                end else if (any_valid == TRUE) begin
                    if (req_op[win] == NOOP) begin
                        ack_d[win] = 1'b1;
                        rr_d       = win;
                    end else begin
                        request_d = req_op[win];
                        data_d    = req_data[win];
                        gid_d     = win;
                        cnt_d     = '0;
                        state_d   = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Done on the expiry cycle counts as a normal completion.
                if (Done || cnt_q == CNT_W'(TIMEOUT_CLOCKS - 1)) begin
                    request_d = NOOP;
                    data_d    = '0;
                    err_d     = ~Done;
                    if (!poll_active) begin
                        ack_d[gid_q] = 1'b1;
                        rr_d         = gid_q;
                    end
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rr_q      <= GID_W'(N_REQ - 1);
            gid_q     <= '0;
            request_q <= NOOP;
            data_q    <= '0;
            ack_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            gid_q     <= gid_d;
            request_q <= request_d;
            data_q    <= data_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign req_ack     = ack_q;
    assign req_err     = err_q;
    assign grant_id    = gid_q;
    assign busy        = (state_q != ST_IDLE);
    assign request     = request_q;
    assign reqData     = data_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tmon_sched.sv
// Self-checking bench for tmon_sched (default build): cycle table, round-robin,
// timeout, reset-abort sequences and randomized transactions against a reference model.
module tb_tmon_sched;
    import tmon_sched_pkg::*;

    localparam int N  = 3;
    localparam int TO = 64;
    localparam int GW = 2;

    logic                  Clock = 1'b0;
    logic                  Reset;
    logic     [N-1:0]      req_valid;
    tmon_op_t [N-1:0]      req_op;
    logic     [N-1:0][7:0] req_data;
    logic     [N-1:0]      req_ack;
    logic                  req_err;
    logic     [GW-1:0]     grant_id;
    logic                  busy;
    tmon_op_t              request;
    logic     [7:0]        reqData;
    logic                  Done;
    logic     [1:0]        dbg_state;

    int errors = 0;
    int checks = 0;
    logic [GW-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 Clock = ~Clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    tmon_sched #(.N_REQ(N), .TIMEOUT_CLOCKS(TO), .POLL_CLOCKS(16)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .req_err     (req_err),
        .grant_id    (grant_id),
        .busy        (busy),
        .request     (request),
        .reqData     (reqData),
        .Done        (Done),
        .dbg_state_o (dbg_state)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int w);
        logic [N-1:0] v;
        v = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    // ---------------- reference model ----------------
    // Next grantee: first requesting index after the last served one, modulo N.
    function automatic int rr_pick(input logic [N-1:0] mask, input int last);
        for (int k = 1; k <= N; k++) begin
            if (mask[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // ---------------- cycle table ----------------
    typedef struct {
        logic [N-1:0] valid;
        int           sel;
        tmon_op_t     op;
        logic [7:0]   data;
        logic         done;
        tmon_op_t     e_req;
        logic [7:0]   e_data;
        logic [N-1:0] e_ack;
        logic         e_err;
        logic         e_busy;
        logic [GW-1:0] e_gid;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int model_last;
        int n;
        logic early;

        vecs[0]  = '{3'b001, 0, READ_TEMP, 8'h00, 1'b0, READ_TEMP, 8'h00, 3'b000, 1'b0, 1'b1, 2'd0};
        vecs[1]  = '{3'b001, 0, READ_TEMP, 8'h00, 1'b0, READ_TEMP, 8'h00, 3'b000, 1'b0, 1'b1, 2'd0};
        vecs[2]  = '{3'b001, 0, READ_TEMP, 8'h00, 1'b0, READ_TEMP, 8'h00, 3'b000, 1'b0, 1'b1, 2'd0};
        vecs[3]  = '{3'b001, 0, READ_TEMP, 8'h00, 1'b1, NOOP,      8'h00, 3'b001, 1'b0, 1'b1, 2'd0};
        vecs[4]  = '{3'b000, 0, NOOP,      8'h00, 1'b0, NOOP,      8'h00, 3'b000, 1'b0, 1'b0, 2'd0};
        vecs[5]  = '{3'b010, 1, SET_HI,    8'h50, 1'b0, SET_HI,    8'h50, 3'b000, 1'b0, 1'b1, 2'd1};
        vecs[6]  = '{3'b010, 1, SET_HI,    8'h50, 1'b1, NOOP,      8'h00, 3'b010, 1'b0, 1'b1, 2'd1};
        vecs[7]  = '{3'b000, 1, NOOP,      8'h00, 1'b0, NOOP,      8'h00, 3'b000, 1'b0, 1'b0, 2'd1};
        vecs[8]  = '{3'b100, 2, NOOP,      8'h00, 1'b0, NOOP,      8'h00, 3'b100, 1'b0, 1'b0, 2'd1};
        vecs[9]  = '{3'b000, 2, NOOP,      8'h00, 1'b0, NOOP,      8'h00, 3'b000, 1'b0, 1'b0, 2'd1};
        vecs[10] = '{3'b000, 0, NOOP,      8'h00, 1'b1, NOOP,      8'h00, 3'b000, 1'b0, 1'b0, 2'd1};

        Reset     = 1'b0;
        req_valid = '0;
        Done      = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_op[i]   = NOOP;
            req_data[i] = 8'h00;
        end

        // ---- reset state ----
        repeat (4) tick();
        check("reset_request", request, NOOP);
        check("reset_reqData", reqData, 8'h00);
        check("reset_ack", req_ack, 3'b000);
        check("reset_err", req_err, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_grant_id", grant_id, 2'd0);
        Reset = 1'b1;

        // ---- cycle table ----
        for (int r = 0; r < 11; r++) begin
            req_valid           = vecs[r].valid;
            req_op[vecs[r].sel]   = vecs[r].op;
            req_data[vecs[r].sel] = vecs[r].data;
            Done                = vecs[r].done;
            tick();
            check($sformatf("vec%0d_request", r), request, vecs[r].e_req);
            check($sformatf("vec%0d_reqData", r), reqData, vecs[r].e_data);
            check($sformatf("vec%0d_ack", r), req_ack, vecs[r].e_ack);
            check($sformatf("vec%0d_err", r), req_err, vecs[r].e_err);
            check($sformatf("vec%0d_busy", r), busy, vecs[r].e_busy);
            check($sformatf("vec%0d_grant_id", r), grant_id, vecs[r].e_gid);
        end
        Done = 1'b0;

        // ---- round-robin with all requesters continuously valid ----
        for (int i = 0; i < N; i++) begin
            req_op[i]   = SET_LO;
            req_data[i] = 8'(8'h10 + i);
        end
        for (int k = 0; k < 6; k++) exp_q.push_back(GW'(k % N));
        req_valid = '1;
        for (int t = 0; t < 6; t++) begin
            logic [GW-1:0] g;
            g = exp_q.pop_front();
            tick();
            check("rr_issue_busy", busy, 1'b1);
            check("rr_grant", grant_id, g);
            check("rr_request", request, SET_LO);
            check("rr_reqData", reqData, 8'(8'h10 + g));
            tick();
            Done = 1'b1;
            tick();
            Done = 1'b0;
            check("rr_ack", req_ack, onehot(int'(g)));
            check("rr_gap_request", request, NOOP);
            tick();
            check("rr_gap_done_busy", busy, 1'b0);
            check("rr_gap_done_ack", req_ack, 3'b000);
        end
        req_valid = '0;
        tick();

        // ---- timeout: requester 1, Done never arrives ----
        req_valid   = 3'b010;
        req_op[1]   = SET_HI;
        req_data[1] = 8'h50;
        tick();
        check("to_request", request, SET_HI);
        check("to_reqData", reqData, 8'h50);
        check("to_grant", grant_id, 2'd1);
        n = 0;
        while (n < TO + 8) begin
            tick();
            n++;
            if (req_ack != '0) break;
        end
        check("to_cycles", n, TO);
        check("to_ack", req_ack, 3'b010);
        check("to_err", req_err, 1'b1);
        check("to_request_noop", request, NOOP);
        req_valid = '0;
        tick();
        check("to_err_pulse", req_err, 1'b0);
        check("to_ack_pulse", req_ack, 3'b000);
        check("to_busy_idle", busy, 1'b0);

        // ---- Done on the expiry cycle wins over timeout ----
        req_valid   = 3'b001;
        req_op[0]   = READ_STAT;
        req_data[0] = 8'h3C;
        tick();
        check("exp_grant", grant_id, 2'd0);
        early = 1'b0;
        for (int c = 0; c < TO - 1; c++) begin
            tick();
            if (req_ack != '0 || req_err) early = 1'b1;
        end
        check("exp_no_early_ack", early, 1'b0);
        Done = 1'b1;
        tick();
        Done = 1'b0;
        check("exp_ack", req_ack, 3'b001);
        check("exp_err", req_err, 1'b0);
        req_valid = '0;
        tick();
        tick();

        // ---- reset mid-WAIT ----
        req_valid   = 3'b100;
        req_op[2]   = READ_TEMP;
        req_data[2] = 8'h77;
        tick();
        check("rst_grant_before", grant_id, 2'd2);
        tick();
        tick();
        #2;
        Reset = 1'b0;
        #1;
        check("rst_async_request", request, NOOP);
        check("rst_async_reqData", reqData, 8'h00);
        check("rst_async_busy", busy, 1'b0);
        check("rst_async_grant", grant_id, 2'd0);
        check("rst_async_ack", req_ack, 3'b000);
        repeat (2) tick();
        check("rst_hold_ack", req_ack, 3'b000);
        check("rst_hold_err", req_err, 1'b0);
        Reset = 1'b1;
        for (int i = 0; i < N; i++) req_op[i] = READ_TEMP;
        req_valid = 3'b111;
        tick();
        check("rst_next_grant", grant_id, 2'd0);
        check("rst_next_request", request, READ_TEMP);
        Done = 1'b1;
        tick();
        Done = 1'b0;
        check("rst_next_ack", req_ack, 3'b001);
        req_valid = '0;
        tick();
        tick();
        model_last = 0;

        // ---- randomized transactions against the reference model ----
        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] mask;
            int w;
            int d;
            int exp_n;
            tmon_op_t exp_op;
            logic [7:0] exp_data;

            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                req_op[i]   = tmon_op_t'($urandom_range(0, 4));
                req_data[i] = 8'($urandom);
            end
            w = rr_pick(mask, model_last);
            exp_q.push_back(GW'(w));
            exp_op    = req_op[w];
            exp_data  = req_data[w];
            req_valid = mask;
            tick();
            if (exp_op == NOOP) begin
                check("rnd_noop_ack", req_ack, onehot(int'(exp_q.pop_front())));
                check("rnd_noop_busy", busy, 1'b0);
                check("rnd_noop_request", request, NOOP);
            end else begin
                check("rnd_grant", grant_id, exp_q.pop_front());
                check("rnd_request", request, exp_op);
                check("rnd_reqData", reqData, exp_data);
                check("rnd_busy", busy, 1'b1);
                d = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(1, 5);
                n = 0;
                while (n < TO + 4) begin
                    req_valid = N'($urandom) | onehot(w);
                    Done      = (n + 1 == d);
                    tick();
                    n++;
                    if (req_ack != '0) break;
                    check("rnd_hold_request", request, exp_op);
                end
                Done  = 1'b0;
                exp_n = (d <= TO) ? d : TO;
                check("rnd_latency", n, exp_n);
                check("rnd_ack", req_ack, onehot(w));
                check("rnd_err", req_err, (d > TO) ? 1'b1 : 1'b0);
                check("rnd_done_request", request, NOOP);
            end
            model_last = w;
            req_valid  = '0;
            tick();
            check("rnd_ack_pulse", req_ack, 3'b000);
            check("rnd_err_pulse", req_err, 1'b0);
            tick();
            check("rnd_idle_busy", busy, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tmon_sched.md
Name: tmon_sched

Overview:
- Request scheduler in front of tmon_master; shares the single master request port among N_REQ requesters (host CSR path, alarm logic, debug).
- Round-robin arbitration; issues one TMON_OP at a time on request/reqData and holds it until the master's Done.
- Returns a per-requester ack, or an error if Done never arrives within TIMEOUT_CLOCKS.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- TIMEOUT_CLOCKS, 64, max WAIT cycles before abort (>=2).
- POLL_CLOCKS, 16, autopoll period in clocks (used only with TMON_AUTOPOLL_EN).

Ports:
- Clock  in  1  system clock, posedge.
- Reset  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester request; held high until ack.
- req_op  in  N_REQ x TMON_OP  per-requester opcode; stable while valid.
- req_data  in  N_REQ x 8  per-requester operand.
- req_ack  out  N_REQ  one-cycle completion pulse, one-hot.
- req_err  out  1  one-cycle pulse with req_ack on timeout abort.
- grant_id  out  $clog2(N_REQ)  index of current or last grantee.
- busy  out  1  high in WAIT and GAP.
- request  out  TMON_OP  to tmon_master.
- reqData  out  8  to tmon_master.
- Done  in  1  completion pulse from tmon_master.

Behaviour:
- Reset (async, Reset==0):
  - request=NOOP, reqData=0, req_ack=0, req_err=0, busy=0, grant_id=0.
  - State IDLE; timeout counter 0; rr pointer = N_REQ-1, so requester 0 wins first.
  - Reset mid-WAIT aborts silently, with no ack.
- States: IDLE -> WAIT -> GAP -> IDLE.
- IDLE:
  - On posedge with any req_valid, pick winner g: first valid index after the rr pointer, wrapping modulo N_REQ.
  - If req_op[g]==NOOP: req_ack[g]=1 next cycle, stay IDLE, rr pointer=g, bus untouched.
  - Otherwise: request<=req_op[g], reqData<=req_data[g], grant_id<=g, counter<=0, go WAIT.
  - Latency: valid sampled at edge k, request visible after edge k.
- WAIT:
  - request/reqData held constant; counter increments each cycle.
  - Done==1: request<=NOOP, reqData<=0, req_ack[g]<=1 for one cycle, rr pointer<=g, go GAP.
  - Counter reaches TIMEOUT_CLOCKS-1 with Done==0: same as Done, plus req_err<=1 for one cycle.
  - Done in the expiry cycle wins: no error.
- GAP:
  - Exactly one cycle with request=NOOP, so the master sees a separator; then IDLE.
  - Requester must drop valid the cycle after ack; a still-high valid in the next IDLE is a new request.
- Done outside WAIT is ignored.
- Back-to-back ops: minimum 3 cycles per op (issue, Done, GAP).
- Fairness: the winner becomes lowest priority; any continuously valid requester is served within N_REQ grants.
- req_valid changing during WAIT has no effect on the current grant.

Optional Feature:
- Macro: TMON_AUTOPOLL_EN.
- Defined:
  - A free-running counter sets poll_pending every POLL_CLOCKS clocks; multiple expiries coalesce into one pending poll.
  - In IDLE, poll_pending has absolute priority over all requesters. It issues request=READ_TEMP, reqData=0 and clears poll_pending.
  - On completion it produces no req_ack and leaves the rr pointer unchanged. grant_id is unchanged.
  - Timeout still pulses req_err.
- Undefined: no poll logic; only external requesters.

Decomposition:
- Shared package (defs):
  - TMON_OP enum: NOOP, READ_TEMP, SET_HI, SET_LO, READ_STAT.
  - bool_t with TRUE/FALSE.
  - TMON_DATA_W=8.
  - sched state enum: IDLE, WAIT, GAP.
- Sub-module tmon_rr_arb (combinational):
  - Inputs: valid vector, rr pointer.
  - Outputs: winner index, any_valid.
- tmon_sched owns the state, counter, and pointer registers.

Test Plan:
- Reset low 4 clocks, then high; req_valid=3'b001, op=READ_TEMP, data=8'h00. Expect request=READ_TEMP one cycle after sampling; Done after 3 cycles; then req_ack=3'b001 pulse, request=NOOP, busy low after GAP.
- All three valid continuously, Done returned 2 cycles after each issue. Expect grant order 0,1,2,0,1,2, with a NOOP GAP between each.
- Requester 1 op=SET_HI, data=8'h50, Done never asserted. After TIMEOUT_CLOCKS=64 WAIT cycles: request=NOOP, req_ack[1]=1, req_err=1 in the same cycle.
- Done asserted in the same cycle the counter hits 63. Expect ack with req_err=0.
- Drop Reset mid-WAIT. All outputs go to reset values immediately; no ack; next grant goes to requester 0.
- With TMON_AUTOPOLL_EN, POLL_CLOCKS=16, requester 2 continuously valid: READ_TEMP issued about every 16 clocks ahead of requester 2; req_ack never pulses for polls.
